data_fifo: RTL and testbench
============================

Name: data_fifo

Overview:
- Synchronous first-in/first-out buffer with valid/ready handshakes on both the write and read sides.
- Decouples a producer, such as the keyboard/UART move decoder, from a consumer that pulls data at its own pace, such as the game-logic or VGA char path.
- Complements the fixed-latency delay line: here the reader decides when data leaves.
- Output is first-word-fall-through (FWFT): the head word is presented on rd_data whenever rd_valid is high.

Parameters:
- WIDTH, 8: bit width of each stored word.
- DEPTH, 16: number of storage entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- clk  input  1  posedge-active clock.
- rst  input  1  asynchronous reset, active-high.
- wr_valid  input  1  producer has a word on wr_data.
- wr_ready  output  1  FIFO can accept a word (not full).
- wr_data  input  WIDTH  word to write.
- rd_valid  output  1  rd_data holds a valid head word (not empty).
- rd_ready  input  1  consumer accepts the head word this cycle.
- rd_data  output  WIDTH  head word (FWFT).
- overflow  output  1  sticky flag: a write was attempted while full.
- underflow  output  1  sticky flag: a read was attempted while empty.
- level  output  AW+1  current occupancy; exists only with FIFO_LEVEL_EN.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - wr_ready=1, rd_valid=0, rd_data=0, overflow=0, underflow=0, level=0.
  - Memory contents are don't-care.
- Push = wr_valid & wr_ready. Pop = rd_valid & rd_ready. Both are evaluated on the posedge.
- Push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (natural AW-bit rollover).
- Pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Flag and data outputs:
  - wr_ready = (count != DEPTH).
  - rd_valid = (count != 0).
  - Both are registered, or derived combinationally from registered count; no combinational path from wr_valid/rd_ready to wr_ready/rd_valid.
  - rd_data = mem[rd_ptr] while rd_valid. rd_data is 0 when empty, after reset; after the FIFO drains it holds the last value (don't-care).
- Latency: a word pushed into an empty FIFO at edge N appears with rd_valid=1 after edge N; a consumer with rd_ready=1 can pop it at edge N+1. There is no write-to-read bypass in the same cycle.
- Boundary conditions:
  - Full: wr_ready=0, so wr_valid is ignored and data is dropped. If wr_valid=1 while full, overflow <= 1 (sticky until reset). A simultaneous pop while full frees one slot from the next cycle; the write in that same cycle is still rejected.
  - Empty: rd_valid=0, so rd_ready is ignored. If rd_ready=1 while empty, underflow <= 1 (sticky until reset). A simultaneous push while empty is accepted.
  - Push and pop in the same cycle with 0<count<DEPTH: both occur, count is unchanged, and the ordering is preserved.
  - Wrap-around: after DEPTH pushes and pops, pointers return to 0 and data order stays strict FIFO.
  - Reset mid-operation: all content is discarded immediately; the state after reset equals the power-up state.
- wr_data/rd_ready may change arbitrarily while they are not qualified by the handshake.

Optional Feature:
- Macro: FIFO_LEVEL_EN.
- Defined: port level [AW:0] is present. level = count, updated on the same edge as count, reset value 0, range 0..DEPTH.
- Undefined: the level port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: rst pulse, no traffic -> wr_ready=1, rd_valid=0, rd_data=0, overflow=0, underflow=0, level=0.
- Fill and drain, DEPTH=16:
  - Push 0x01..0x10 with rd_ready=0 -> after the 16th push wr_ready=0, level=16.
  - Then rd_ready=1 -> rd_data reads 0x01..0x10 in order, one per cycle; afterwards rd_valid=0, wr_ready=1.
- Overflow/underflow:
  - While full, drive wr_valid=1 with 0xAA -> word dropped, overflow=1 and stays 1; drain returns no 0xAA.
  - rd_ready=1 while empty -> underflow=1.
- Simultaneous push/pop: preload 3 words (0x11,0x22,0x33), then 10 cycles with wr_valid=rd_ready=1 pushing 0x40..0x49 -> level stays 3; pops yield 0x11,0x22,0x33,0x40,...,0x46; the remaining 3 words are 0x47..0x49.
- Wrap-around: 40 push/pop pairs of incrementing data with random rd_ready stalls -> scoreboard shows zero mismatches; pointers cross 15->0 at least twice.
- Reset mid-operation: with 5 words stored, assert rst asynchronously between edges -> rd_valid=0 and level=0 immediately; the first word pushed after release (0x5A) is the first word read.

Source files
------------

// File: rtl/data_fifo.sv
// data_fifo: first-word-fall-through synchronous FIFO with valid/ready on both sides.
// Define FIFO_LEVEL_EN to expose the occupancy port `level`.
module data_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow,
`ifdef FIFO_LEVEL_EN
    output logic             underflow,
    output logic [AW:0]      level
`else
    output logic             underflow
`endif
);

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_push;
    logic             w_pop;

    // Flags come only from registered count, so no input-to-ready path exists.
    assign wr_ready  = (r_count != LP_FULL);
    assign rd_valid  = (r_count != '0);
    assign w_push    = wr_valid & wr_ready;
    assign w_pop     = rd_valid & rd_ready;
    assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef FIFO_LEVEL_EN
    assign level = r_count;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_valid && !wr_ready) begin
                r_overflow <= 1'b1;
            end
            if (rd_ready && !rd_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_fifo.sv
// tb_data_fifo: directed stimulus with a queue scoreboard drained by a read-side monitor.
// Level checks are compiled in when FIFO_LEVEL_EN is defined.
module tb_data_fifo;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       overflow;
    logic       underflow;
`ifdef FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    data_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .overflow (overflow),
`ifdef FIFO_LEVEL_EN
        .underflow(underflow),
        .level    (level)
`else
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (exp_q.size() > 0 && n < 64) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: a word leaves at the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected got=%h want=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", rd_data, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int n;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("idle_wr_ready", wr_ready, 1);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_rd_data", rd_data, 0);
        chk("idle_overflow", overflow, 0);
        chk("idle_underflow", underflow, 0);
`ifdef FIFO_LEVEL_EN
        chk("idle_level", level, 0);
`endif

        for (int i = 1; i <= 16; i++) begin
            chk("fill_wr_ready", wr_ready, 1);
            push(8'(i));
        end
        chk("full_wr_ready", wr_ready, 0);
        chk("full_rd_valid", rd_valid, 1);
        chk("full_head", rd_data, 8'h01);
`ifdef FIFO_LEVEL_EN
        chk("full_level", level, 16);
`endif

        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        tick();
        wr_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_still_full", wr_ready, 0);
        tick();
        tick();
        chk("ovf_sticky", overflow, 1);

        // Pop and blocked write on the same full cycle: only the pop happens.
        wr_valid = 1'b1;
        wr_data  = 8'hBB;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("fullpop_wr_ready", wr_ready, 1);
`ifdef FIFO_LEVEL_EN
        chk("fullpop_level", level, 15);
`endif

        drain();
        chk("drained_rd_valid", rd_valid, 0);
        chk("drained_wr_ready", wr_ready, 1);
        chk("drained_underflow", underflow, 0);

        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("udf_set", underflow, 1);
        chk("udf_rd_valid", rd_valid, 0);

        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            rd_ready = 1'b1;
            wr_data  = 8'(8'h40 + i);
            exp_q.push_back(wr_data);
            tick();
            chk("sim_rd_valid", rd_valid, 1);
            chk("sim_wr_ready", wr_ready, 1);
`ifdef FIFO_LEVEL_EN
            chk("sim_level", level, 3);
`endif
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("sim_head", rd_data, 8'h47);
        drain();

        sent = 0;
        n    = 0;
        while ((sent < 40 || exp_q.size() > 0) && n < 400) begin
            if (sent < 40) begin
                wr_valid = 1'b1;
                wr_data  = 8'(8'h80 + sent);
                if (wr_ready) begin
                    exp_q.push_back(wr_data);
                    sent++;
                end
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("wrap_sent", sent, 40);
        chk("wrap_left", exp_q.size(), 0);
        tick();
        chk("wrap_rd_valid", rd_valid, 0);

        for (int i = 0; i < 5; i++) begin
            push(8'(8'h61 + i));
        end
        chk("pre_rst_rd_valid", rd_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`ifdef FIFO_LEVEL_EN
        chk("rst_level", level, 0);
`endif
        tick();
        rst = 1'b0;
        tick();
        push(8'h5A);
        chk("post_rst_head", rd_data, 8'h5A);
        drain();
        chk("end_rd_valid", rd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
